// File: rtl/uart_rx_multi.sv
// Oversampled UART receiver: run-time frame format, 3-sample majority vote, valid/ready output.
// Define UART_RX_BREAK_DET_EN to add the Break_Det output.
module uart_rx_multi #(
  parameter int DATA_WIDTH = 9,
  parameter int PRESC_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic [3:0]            DATA_LEN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_valid,
  input  logic                  Data_ready,
  output logic                  Parity_Error,
  output logic                  Stop_Error,
`ifdef UART_RX_BREAK_DET_EN
  output logic                  Break_Det,
`endif
  output logic                  Overrun
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, DONE
  } state_t;

  state_t state, state_n;

  logic                  rx_m, rx_s, arm;
  logic [PRESC_W-1:0]    edge_cnt, p_l, c;
  logic [3:0]            len_l, bit_cnt;
  logic                  par_en_l, par_typ_l, stop2_l;
  logic                  stop_cnt;
  logic                  s0, s1, maj;
  logic [DATA_WIDTH-1:0] shadow;
  logic                  par_err, stop_err;
  logic                  at_lo, at_c, at_mid, at_end;
  logic                  publish;
  logic [PRESC_W-1:0]    p_eff;
  logic [3:0]            len_eff;

  assign p_eff = (Prescale < PRESC_W'(8)) ? PRESC_W'(8) : Prescale;
  assign len_eff = (DATA_LEN < 4'd5 || DATA_LEN > 4'(DATA_WIDTH))
                 ? 4'(DATA_WIDTH) : DATA_LEN;

  assign c      = p_l >> 1;
  assign at_lo  = edge_cnt == c - PRESC_W'(1);
  assign at_c   = edge_cnt == c;
  assign at_mid = edge_cnt == c + PRESC_W'(1);
  assign at_end = edge_cnt == p_l - PRESC_W'(1);
  assign maj    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

  assign publish = (state == DONE) && (!Data_valid || Data_ready);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (!rx_s && arm) state_n = START;
      START:   if (at_mid && maj) state_n = IDLE;
               else if (at_end) state_n = DATA;
      DATA:    if (at_end && bit_cnt == len_l - 4'd1)
                 state_n = par_en_l ? PARITY : STOP;
      PARITY:  if (at_end) state_n = STOP;
      STOP:    if (at_mid && stop_cnt == stop2_l) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      arm       <= 1'b0;
      edge_cnt  <= '0;
      p_l       <= PRESC_W'(8);
      len_l     <= 4'(DATA_WIDTH);
      par_en_l  <= 1'b0;
      par_typ_l <= 1'b0;
      stop2_l   <= 1'b0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      shadow    <= '0;
      par_err   <= 1'b0;
      stop_err  <= 1'b0;
    end else begin
      rx_m <= RX_IN;
      rx_s <= rx_m;
      // After a bad stop the line must go high before a new start is accepted
      if (state == DONE) arm <= stop_err ? rx_s : 1'b1;
      else if (rx_s)     arm <= 1'b1;
      if (state == IDLE || state_n != state || at_end) edge_cnt <= '0;
      else edge_cnt <= edge_cnt + PRESC_W'(1);
      if (at_lo) s0 <= rx_s;
      if (at_c)  s1 <= rx_s;
      if (state == IDLE && state_n == START) begin
        p_l       <= p_eff;
        len_l     <= len_eff;
        par_en_l  <= PAR_EN;
        par_typ_l <= PAR_TYP;
        stop2_l   <= STOP2;
        bit_cnt   <= '0;
        stop_cnt  <= 1'b0;
        shadow    <= '0;
        par_err   <= 1'b0;
        stop_err  <= 1'b0;
      end
      if (state == DATA) begin
        if (at_mid) shadow <= shadow | (DATA_WIDTH'(maj) << bit_cnt);
        if (at_end) bit_cnt <= bit_cnt + 4'd1;
      end
      if (state == PARITY && at_mid)
        par_err <= maj != (^shadow ^ par_typ_l);
      if (state == STOP) begin
        if (at_mid && !maj) stop_err <= 1'b1;
        if (at_end) stop_cnt <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      P_DATA       <= '0;
      Data_valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      Overrun <= (state == DONE) && !publish;
      if (publish) begin
        P_DATA       <= shadow;
        Parity_Error <= par_err;
        Stop_Error   <= stop_err;
        Data_valid   <= 1'b1;
      end else if (Data_valid && Data_ready) begin
        Data_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic all_zero;

  // Tracks data, parity and first stop all sampling low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      all_zero  <= 1'b0;
      Break_Det <= 1'b0;
    end else begin
      if (state == IDLE && state_n == START)
        all_zero <= 1'b1;
      else if (at_mid && maj &&
               (state == DATA || state == PARITY ||
                (state == STOP && !stop_cnt)))
        all_zero <= 1'b0;
      if (publish) Break_Det <= all_zero & stop_err;
      else if (Data_valid && Data_ready) Break_Det <= 1'b0;
    end
  end
`endif

endmodule
